// File: rtl/seq_alu_defs.sv
// -----------------------------------------------------------------------------
// seq_alu_defs
// Shared definitions for the registered Hack-style ALU (seq_alu) and its
// combinational core (alu_core_w).
//   - state_t       : FSM encoding, ST_IDLE / ST_MUL
//   - DEFAULT_WIDTH : default operand/result width
// -----------------------------------------------------------------------------
package seq_alu_defs;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 16;

endpackage : seq_alu_defs

// File: rtl/alu_core_w.sv
// -----------------------------------------------------------------------------
// alu_core_w
// Purely combinational Hack ALU function at generic WIDTH.
// Ports:
//   x, y                  in   WIDTH  operands
//   zx, nx, zy, ny, f, no in   1      Hack control bits
//   a, b                  out  WIDTH  preprocessed operands (zero/negate applied)
//   r_out                 out  WIDTH  final result (after optional inversion)
//   carry                 out  1      carry out of a+b when f=1, else 0
// -----------------------------------------------------------------------------
module alu_core_w #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r_out,
   output logic             carry
);

   logic [WIDTH-1:0] x_z;
   logic [WIDTH-1:0] y_z;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] r;

   assign x_z = zx ? '0 : x;
   assign y_z = zy ? '0 : y;
   assign a   = nx ? ~x_z : x_z;
   assign b   = ny ? ~y_z : y_z;

   // One extra bit on the adder so the carry falls out of the same sum.
   assign sum   = {1'b0, a} + {1'b0, b};
   assign r     = f ? sum[WIDTH-1:0] : (a & b);
   assign r_out = no ? ~r : r;
   assign carry = f & sum[WIDTH];

endmodule : alu_core_w

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Registered successor to the Hack ALU. Single-cycle Hack operations (latency
// 1, back-to-back accepted) plus a shift-add multiply taking WIDTH steps.
// Ports:
//   clock                 in   1      system clock, rising edge
//   reset                 in   1      asynchronous, active-high
//   start                 in   1      request, sampled only in IDLE
//   x, y                  in   WIDTH  operands (two's complement)
//   zx, nx, zy, ny, f, no in   1      Hack control bits
//   mul                   in   1      1 = multiply (f ignored)
//   out                   out  WIDTH  registered result
//   zr, ng, cy            out  1      registered zero / negative / carry flags
//   busy                  out  1      multiply in progress
//   done                  out  1      one-cycle pulse, result valid from then on
// -----------------------------------------------------------------------------
module seq_alu
   import seq_alu_defs::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   input  logic             mul,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             cy,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             lno_q, lno_d;
   logic [WIDTH-1:0] out_d;
   logic             zr_d, ng_d, cy_d, done_d;

   logic [WIDTH-1:0] core_a, core_b, core_r;
   logic             core_carry;
   logic [WIDTH-1:0] acc_step;

   alu_core_w #(.WIDTH(WIDTH)) u_core (
      .x     (x),
      .y     (y),
      .zx    (zx),
      .nx    (nx),
      .zy    (zy),
      .ny    (ny),
      .f     (f),
      .no    (no),
      .a     (core_a),
      .b     (core_b),
      .r_out (core_r),
      .carry (core_carry)
   );

   // busy is a pure decode of the registered state, so it is glitch-free.
   assign busy = (state_q == ST_MUL);

   // Accumulator value after this cycle's shift-add step.
   assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      // NOTE: every signal gets a hold/default value first so no path leaves
      // it unassigned; otherwise a latch would be inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      lno_d    = lno_q;
      out_d    = out;
      cy_d     = cy;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (mul) begin
                  state_d  = ST_MUL;
                  mcand_d  = core_a;
                  mplier_d = core_b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  lno_d    = no;
               end else begin
                  out_d  = core_r;
                  cy_d   = core_carry;
                  done_d = 1'b1;
               end
            end
         end

         ST_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNTW'(1);
            if (cnt_d == CNTW'(WIDTH)) begin
               out_d   = lno_q ? ~acc_step : acc_step;
               cy_d    = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Flags always follow the value being written to out.
      zr_d = (out_d == '0);
      ng_d = out_d[WIDTH-1];
   end

   // NOTE: the multiply datapath registers are reset along with the control
   // state so an aborted multiply leaves no stale partial product behind.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         lno_q    <= 1'b0;
         out      <= '0;
         zr       <= 1'b1;
         ng       <= 1'b0;
         cy       <= 1'b0;
         done     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values of the others, independent of statement order.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         lno_q    <= lno_d;
         out      <= out_d;
         zr       <= zr_d;
         ng       <= ng_d;
         cy       <= cy_d;
         done     <= done_d;
      end
   end

endmodule : seq_alu

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 16-bit Hack ALU.
- Keeps the six Hack control bits (zx, nx, zy, ny, f, no) and the zr/ng flags at generic WIDTH.
- Adds a carry-out flag and a multi-cycle shift-add multiply mode behind a start/busy/done handshake.
- Serves as the execute unit of the next CPU datapath revision; the CPU stalls on busy.

Parameters:
- WIDTH, 16, operand/result width in bits (min 4).
- CNTW, $clog2(WIDTH+1), multiply step-counter width (derived; do not override).

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  operand x (two's complement).
- y  input  WIDTH  operand y (two's complement).
- zx, nx, zy, ny, f, no  input  1 each  Hack control bits.
- mul  input  1  1 = multiply mode; f is ignored.
- out  output  WIDTH  registered result.
- zr  output  1  registered: out == 0.
- ng  output  1  registered: out[WIDTH-1].
- cy  output  1  registered: carry out of the x+y adder; 0 for AND and multiply.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; result valid on out/flags from that cycle on.

Behaviour:
- Reset values: out=0, zr=1, ng=0, cy=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-multiply aborts the operation: no done pulse, and the partial product is discarded.
- Operand preprocessing (all modes):
  - a = zx ? 0 : x, then a = nx ? ~a : a.
  - b built the same way from y with zy/ny.
- State IDLE:
  - start=0 → stay; out and flags hold.
  - start=1, mul=0 → at that edge, load r = f ? a+b : a&b, then out = no ? ~r : r. cy = carry bit WIDTH of a+b (before no) when f=1, else 0. done=1 for the next cycle. Stay IDLE (latency 1; back-to-back starts are accepted every cycle).
  - start=1, mul=1 → latch multiplicand=a, multiplier=b, acc=0, counter=0, and the no bit; busy=1; go to MUL.
- State MUL, one step per cycle:
  - If multiplier[0], acc += multiplicand (modulo 2^WIDTH).
  - Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - On the step where counter reaches WIDTH: out = latched_no ? ~acc : acc; cy=0; busy=0; done=1 next cycle; go to IDLE.
- Multiply timing: start sampled at edge n; done is high during the cycle after edge n+WIDTH; busy is high from after edge n until after edge n+WIDTH.
- Result is the low WIDTH bits of a*b, which are sign-agnostic, so signed operands are correct modulo 2^WIDTH. No overflow detection.
- start while busy is ignored. Operands and control bits may change after acceptance without effect.
- zr/ng are always recomputed from the value written to out, in the same edge.
- out and flags hold between operations; done never asserts without a preceding accepted start.

Decomposition:
- Shared package/header (seq_alu_defs): state encodings ST_IDLE=1'b0, ST_MUL=1'b1; the default WIDTH constant.
- Sub-module alu_core_w (parameter WIDTH): purely combinational Hack function including preprocessing, producing r_out and carry.
  - Instanced once in seq_alu for the single-cycle path.
  - The preprocessing outputs a/b are also exported for the multiply latch.
- The FSM, counter and shift-add datapath live in seq_alu.

Test Plan:
- Add, WIDTH=16: x=4, y=1, f=1, other bits 0, mul=0, start one cycle → next cycle out=5, zr=0, ng=0, cy=0, done=1 for exactly one cycle, busy stays 0.
- Subtract x-y: x=4, y=1, nx=1, f=1, no=1 → out=3. Same with x=1, y=4 → out=-3 (16'hFFFD), ng=1.
- Carry/zero: x=16'hFFFF, y=1, f=1 → out=0, zr=1, cy=1. Then AND with f=0, x=16'hF0F0, y=16'h0FF0 → out=16'h00F0, cy=0.
- Multiply: x=-3, y=7, mul=1 → busy high 16 cycles; start pulses during busy ignored; done exactly 16 cycles after acceptance; out=-21 (16'hFFEB), ng=1. Repeat with no=1 → out=16'h0014.
- Reset mid-multiply: x=100, y=100, mul=1, assert reset asynchronously at cycle 5 → out=0, zr=1, busy=0 immediately, no done pulse. A subsequent add of 2+2 gives 4.
- WIDTH=8 instance: x=8'h7F, y=8'h7F, f=1 → out=8'hFE, ng=1, cy=0. Multiply 8'h10*8'h10 → out=0, zr=1, done 8 cycles after start.
